// File: rtl/decode_stage_if.sv
// Fetch-side request, writeback port and registered decode results for decode_stage.
// The master drives the fetch/writeback inputs and the slave (decode_stage) drives the results.
interface decode_stage_if;
  logic        i_VALID;
  logic [31:0] i_PC;
  logic [31:0] i_INSTRUCTION;
  logic        i_STALL;
  logic        i_FLUSH;
  logic [31:0] i_WB_RD;
  logic [4:0]  i_WB_RD_PTR;
  logic        i_WB_WE;

  logic        o_VALID;
  logic [31:0] o_PC;
  logic [31:0] o_INSTRUCTION;
  logic [2:0]  o_FUNCT3;
  logic [6:0]  o_FUNCT7;
  logic [4:0]  o_RD_PTR;
  logic [31:0] o_RS1;
  logic [31:0] o_RS2;
  logic [31:0] o_IMM_VAL;
  logic        o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM, o_JAL, o_LUI, o_AUIPC;
  logic        o_BRANCH, o_JALR;
  logic        o_ILLEGAL;

  modport master (
    output i_VALID, i_PC, i_INSTRUCTION, i_STALL, i_FLUSH, i_WB_RD, i_WB_RD_PTR, i_WB_WE,
    input  o_VALID, o_PC, o_INSTRUCTION, o_FUNCT3, o_FUNCT7, o_RD_PTR, o_RS1, o_RS2,
           o_IMM_VAL, o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM, o_JAL, o_LUI,
           o_AUIPC, o_BRANCH, o_JALR, o_ILLEGAL
  );

  modport slave (
    input  i_VALID, i_PC, i_INSTRUCTION, i_STALL, i_FLUSH, i_WB_RD, i_WB_RD_PTR, i_WB_WE,
    output o_VALID, o_PC, o_INSTRUCTION, o_FUNCT3, o_FUNCT7, o_RD_PTR, o_RS1, o_RS2,
           o_IMM_VAL, o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM, o_JAL, o_LUI,
           o_AUIPC, o_BRANCH, o_JALR, o_ILLEGAL
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode/operand fetch: one-cycle latency into a single pipeline register.
// Stall holds the register (operands still refresh from writeback); flush beats stall; !i_VALID inserts a bubble.
module decode_stage #(
  parameter int NREGS = 32
) (
  input  logic          i_CLK,
  input  logic          i_RSTn,
  decode_stage_if.slave bus
);
  localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  typedef struct packed {
    logic reg_we, mem_we, mem_re, ecall, imm, jal, lui, auipc, branch, jalr, illegal;
  } ctrl_t;

  logic [31:0] r_regs [NREGS];
  logic        r_valid;
  logic [31:0] r_pc, r_instr, r_rs1, r_rs2, r_imm_val;
  logic [2:0]  r_funct3;
  logic [6:0]  r_funct7;
  logic [4:0]  r_rd_ptr, r_rs1_ptr, r_rs2_ptr;
  ctrl_t       r_ctrl;

  logic [31:0] w_in;
  logic [6:0]  w_op;
  logic [4:0]  w_rd_ptr, w_rs1_ptr, w_rs2_ptr;
  ctrl_t       w_ctrl;
  logic [31:0] w_imm_val, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_use_rd, w_use_rs1, w_use_rs2, w_bad;

  assign w_in      = bus.i_INSTRUCTION;
  assign w_op      = w_in[6:0];
  assign w_rd_ptr  = w_in[11:7];
  assign w_rs1_ptr = w_in[19:15];
  assign w_rs2_ptr = w_in[24:20];

  always_comb begin
    w_ctrl    = '0;
    w_imm_val = '0;
    w_funct3  = w_in[14:12];
    w_funct7  = '0;
    w_use_rd  = 1'b0;
    w_use_rs1 = 1'b0;
    w_use_rs2 = 1'b0;
    w_bad     = 1'b0;
    case (w_op)
      7'b0110111: begin w_ctrl.lui = 1'b1; w_ctrl.imm = 1'b1; w_ctrl.reg_we = 1'b1; w_use_rd = 1'b1;
                        w_funct3 = '0; w_imm_val = {w_in[31:12], 12'b0}; end
      7'b0010111: begin w_ctrl.auipc = 1'b1; w_ctrl.imm = 1'b1; w_ctrl.reg_we = 1'b1; w_use_rd = 1'b1;
                        w_funct3 = '0; w_imm_val = {w_in[31:12], 12'b0}; end
      7'b1101111: begin w_ctrl.jal = 1'b1; w_ctrl.imm = 1'b1; w_ctrl.reg_we = 1'b1; w_use_rd = 1'b1;
                        w_funct3 = '0;
                        w_imm_val = {{11{w_in[31]}}, w_in[31], w_in[19:12], w_in[20], w_in[30:21], 1'b0}; end
      7'b1100111: begin w_ctrl.jalr = 1'b1; w_ctrl.imm = 1'b1; w_ctrl.reg_we = 1'b1;
                        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                        w_imm_val = {{20{w_in[31]}}, w_in[31:20]}; end
      7'b1100011: begin w_ctrl.branch = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                        w_imm_val = {{19{w_in[31]}}, w_in[31], w_in[7], w_in[30:25], w_in[11:8], 1'b0}; end
      7'b0000011: begin w_ctrl.imm = 1'b1; w_ctrl.mem_re = 1'b1; w_ctrl.reg_we = 1'b1;
                        w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                        w_imm_val = {{20{w_in[31]}}, w_in[31:20]}; end
      7'b0100011: begin w_ctrl.imm = 1'b1; w_ctrl.mem_we = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                        w_imm_val = {{20{w_in[31]}}, w_in[31:25], w_in[11:7]}; end
      7'b0010011: begin w_ctrl.imm = 1'b1; w_ctrl.reg_we = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                        w_imm_val = {{20{w_in[31]}}, w_in[31:20]};
                        if (w_in[14:12] == 3'b101) w_funct7 = w_in[31:25]; end
      7'b0110011: begin w_ctrl.reg_we = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                        w_funct7 = w_in[31:25];
                        w_bad = (w_in[31:25] != 7'b0000000) && (w_in[31:25] != 7'b0100000); end
      7'b1110011: begin w_ctrl.ecall = 1'b1; w_ctrl.reg_we = 1'b1; w_use_rd = 1'b1; w_use_rs1 = 1'b1;
                        w_imm_val = {{20{w_in[31]}}, w_in[31:20]}; end
      default:    begin w_bad = 1'b1; w_funct3 = '0; end
    endcase
    // Pointer range only matters for fields the format actually uses (RV32E case).
    if ((w_use_rd  && ({1'b0, w_rd_ptr}  >= NREGS_L)) ||
        (w_use_rs1 && ({1'b0, w_rs1_ptr} >= NREGS_L)) ||
        (w_use_rs2 && ({1'b0, w_rs2_ptr} >= NREGS_L)))
      w_bad = 1'b1;
    if (w_rd_ptr == 5'd0) w_ctrl.reg_we = 1'b0;
    if (w_bad) begin
      w_ctrl.illegal = 1'b1;
      w_ctrl.reg_we  = 1'b0;
      w_ctrl.mem_we  = 1'b0;
      w_ctrl.mem_re  = 1'b0;
      w_ctrl.ecall   = 1'b0;
    end
  end

  // Register read with same-cycle writeback bypass; x0 and out-of-range pointers read 0.
  always_comb begin
    w_rs1 = '0;
    w_rs2 = '0;
    if (w_rs1_ptr != 5'd0) begin
      if (bus.i_WB_WE && bus.i_WB_RD_PTR == w_rs1_ptr) w_rs1 = bus.i_WB_RD;
      else if ({1'b0, w_rs1_ptr} < NREGS_L)            w_rs1 = r_regs[w_rs1_ptr[IW-1:0]];
    end
    if (w_rs2_ptr != 5'd0) begin
      if (bus.i_WB_WE && bus.i_WB_RD_PTR == w_rs2_ptr) w_rs2 = bus.i_WB_RD;
      else if ({1'b0, w_rs2_ptr} < NREGS_L)            w_rs2 = r_regs[w_rs2_ptr[IW-1:0]];
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (bus.i_WB_WE && bus.i_WB_RD_PTR != 5'd0 && {1'b0, bus.i_WB_RD_PTR} < NREGS_L) begin
      r_regs[bus.i_WB_RD_PTR[IW-1:0]] <= bus.i_WB_RD;
    end
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_instr   <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_imm_val <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_rd_ptr  <= '0;
      r_rs1_ptr <= '0;
      r_rs2_ptr <= '0;
      r_ctrl    <= '0;
    end else if (bus.i_FLUSH) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (bus.i_STALL) begin
      if (bus.i_WB_WE && bus.i_WB_RD_PTR != 5'd0 && bus.i_WB_RD_PTR == r_rs1_ptr) r_rs1 <= bus.i_WB_RD;
      if (bus.i_WB_WE && bus.i_WB_RD_PTR != 5'd0 && bus.i_WB_RD_PTR == r_rs2_ptr) r_rs2 <= bus.i_WB_RD;
    end else if (!bus.i_VALID) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else begin
      r_valid   <= 1'b1;
      r_pc      <= bus.i_PC;
      r_instr   <= w_in;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_imm_val <= w_imm_val;
      r_funct3  <= w_funct3;
      r_funct7  <= w_funct7;
      r_rd_ptr  <= w_rd_ptr;
      r_rs1_ptr <= w_rs1_ptr;
      r_rs2_ptr <= w_rs2_ptr;
      r_ctrl    <= w_ctrl;
    end
  end

  assign bus.o_VALID       = r_valid;
  assign bus.o_PC          = r_pc;
  assign bus.o_INSTRUCTION = r_instr;
  assign bus.o_FUNCT3      = r_funct3;
  assign bus.o_FUNCT7      = r_funct7;
  assign bus.o_RD_PTR      = r_rd_ptr;
  assign bus.o_RS1         = r_rs1;
  assign bus.o_RS2         = r_rs2;
  assign bus.o_IMM_VAL     = r_imm_val;
  assign bus.o_REG_WE      = r_ctrl.reg_we;
  assign bus.o_MEM_WE      = r_ctrl.mem_we;
  assign bus.o_MEM_RE      = r_ctrl.mem_re;
  assign bus.o_ECALL       = r_ctrl.ecall;
  assign bus.o_IMM         = r_ctrl.imm;
  assign bus.o_JAL         = r_ctrl.jal;
  assign bus.o_LUI         = r_ctrl.lui;
  assign bus.o_AUIPC       = r_ctrl.auipc;
  assign bus.o_BRANCH      = r_ctrl.branch;
  assign bus.o_JALR        = r_ctrl.jalr;
  assign bus.o_ILLEGAL     = r_ctrl.illegal;
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Decode/operand-fetch stage sitting directly upstream of the execute stage.
- Takes a fetched instruction and PC, decodes RV32I fields into the control strobes execute consumes, and reads operands from an internal register file that the writeback path updates.
- Registers all results into a single pipeline register with stall, flush and bubble handling.

Parameters:
NREGS, 32, number of architectural registers (32 for RV32I, 16 for RV32E); register pointers >= NREGS are illegal.

Ports:
i_CLK  in  1  clock, rising edge
i_RSTn  in  1  asynchronous active-low reset
i_VALID  in  1  i_PC/i_INSTRUCTION hold a valid fetched instruction
i_PC  in  32  instruction address
i_INSTRUCTION  in  32  raw instruction word
i_STALL  in  1  hold pipeline register contents
i_FLUSH  in  1  kill the instruction being captured / held
i_WB_RD  in  32  writeback data
i_WB_RD_PTR  in  5  writeback destination
i_WB_WE  in  1  writeback enable
o_VALID  out  1  pipeline register holds a live instruction
o_PC, o_INSTRUCTION  out  32  registered copies
o_FUNCT3  out  3  decoded funct3
o_FUNCT7  out  7  decoded funct7
o_RD_PTR  out  5  destination register
o_RS1, o_RS2  out  32  operand values
o_IMM_VAL  out  32  sign-extended immediate
o_REG_WE, o_MEM_WE, o_MEM_RE, o_ECALL, o_IMM, o_JAL, o_LUI, o_AUIPC  out  1  control strobes
o_BRANCH, o_JALR  out  1  flags for the branch unit
o_ILLEGAL  out  1  registered instruction is illegal

Behaviour:
- Reset (async, i_RSTn=0): every output is 0 and all registers are cleared.
- Register file: NREGS x 32 entries, written on the rising edge when i_WB_WE=1 and i_WB_RD_PTR!=0. x0 always reads 0.
- Read bypass: if i_WB_WE=1, the pointer matches, and the pointer is nonzero, the read returns i_WB_RD in the same cycle.
- Opcode map (instr[6:0]):
  - 0110111 LUI: U-imm, IMM=1.
  - 0010111 AUIPC: U-imm, IMM=1.
  - 1101111 JAL: J-imm, IMM=1.
  - 1100111 JALR: I-imm, IMM=1.
  - 1100011 BRANCH: B-imm, REG_WE=0.
  - 0000011 LOAD: I-imm, IMM=1, MEM_RE=1.
  - 0100011 STORE: S-imm, IMM=1, MEM_WE=1, REG_WE=0.
  - 0010011 OP-IMM: I-imm, IMM=1.
  - 0110011 OP: IMM=0.
  - 1110011 SYSTEM: I-imm, ECALL=1.
  - Any other opcode is illegal.
- REG_WE=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP and SYSTEM, but is forced to 0 when rd=0.
- o_FUNCT3:
  - instr[14:12] for LOAD, STORE, OP, OP-IMM, SYSTEM, BRANCH, JALR.
  - 000 for LUI, AUIPC, JAL.
- o_FUNCT7:
  - instr[31:25] for OP, and for OP-IMM with funct3=101 (SRAI/SRLI).
  - 0 otherwise.
- Illegal conditions: OP with funct7 not in {0000000, 0100000}; rd, rs1 or rs2 pointer >= NREGS. On illegal: o_ILLEGAL=1, o_VALID=1, and REG_WE, MEM_WE, MEM_RE and ECALL are all 0.
- Pipeline register update, evaluated in priority order each rising edge:
  1. i_FLUSH=1: o_VALID, o_ILLEGAL and all control strobes go to 0. Flush overrides stall.
  2. i_STALL=1: all outputs hold, except operand refresh. If i_WB_WE=1 and i_WB_RD_PTR (nonzero) equals the held rs1 or rs2 pointer, the matching o_RS1/o_RS2 is updated to i_WB_RD.
  3. i_VALID=0: insert a bubble; o_VALID=0 and all strobes are 0.
  4. Otherwise: capture the decoded instruction; o_VALID=1.
- Latency: one cycle from i_INSTRUCTION to registered outputs.
- Internal rs1/rs2 pointers are registered alongside the operands so the stall-time refresh can match against them.

Test Plan:
- Reset mid-operation: assert i_RSTn=0 while o_VALID=1 → all outputs 0 immediately (asynchronous), without waiting for a clock edge.
- Immediate and strobe decode: ADDI x5,x1,-4 (0xFFC08293) with x1=10 → next cycle o_RS1=10, o_IMM_VAL=0xFFFFFFFC, o_IMM=1, o_REG_WE=1, o_RD_PTR=5, o_FUNCT3=000, o_FUNCT7=0.
- Writeback bypass: i_WB_WE=1, i_WB_RD_PTR=3, i_WB_RD=0x1234 in the same cycle as ADD x4,x3,x3 → o_RS1=o_RS2=0x1234.
- Stall refresh: hold i_STALL=1 for 3 cycles with a held SUB x7,x2,x6, write x6=0xAA on the 2nd cycle → o_RS2 becomes 0xAA while all other outputs are unchanged.
- Flush beats stall: i_FLUSH=1 and i_STALL=1 together while holding SW x2,8(x1) → o_VALID=0, o_MEM_WE=0 next cycle.
- Illegal and rd=0 handling:
  - Opcode 0x7F → o_ILLEGAL=1, o_VALID=1, all write strobes 0.
  - ADDI x0,x0,1 → o_REG_WE=0.
  - OP with funct7=0x01 → o_ILLEGAL=1.
